// File: rtl/pong_paddle_ctrl.sv
// Button conditioning for the pong core: 2-flop sync, per-bit debounce, frame-rate paddle motion, serve pulse.
// Optional build macro PADDLE_ACCEL_EN enables hold-time paddle acceleration.
module pong_paddle_ctrl #(
  parameter int unsigned Y_W        = 9,
  parameter int unsigned Y_MAX      = 480,
  parameter int unsigned PADDLE_H   = 64,
  parameter int unsigned STEP       = 4,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     btn,
  input  logic           frame_tick,
  output logic [4:0]     btn_db,
  output logic [Y_W-1:0] paddle1_y,
  output logic [Y_W-1:0] paddle2_y,
  output logic           serve
);

  localparam int unsigned CNT_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned YE_W   = Y_W + 1;
  localparam int unsigned Y_LIM  = Y_MAX - PADDLE_H;
  localparam int unsigned Y_RST  = Y_LIM / 2;
  localparam int unsigned HOLD_W = 5;

  logic [4:0]       s1, s2;
  logic [CNT_W-1:0] deb_cnt [5];
  logic             db4_q;
  logic [1:0]       dir [2];
  logic [YE_W-1:0]  step [2];

  // Synchronizer and per-bit debounce: a change is accepted after DEB_CYCLES stable cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      btn_db <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] != btn_db[i]) begin
          if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
            btn_db[i]  <= ~btn_db[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Direction encoded {down, up}; both or neither means hold.
  assign dir[0] = btn_db[1:0];
  assign dir[1] = btn_db[3:2];

`ifdef PADDLE_ACCEL_EN
  logic [HOLD_W-1:0] hold_cnt [2];
  logic [HOLD_W-1:0] eff_cnt [2];
  logic [1:0]        last_dir [2];

  // A reversal since the last tick restarts acceleration from the base step.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      eff_cnt[p] = '0;
      step[p]    = YE_W'(STEP);
      if (dir[p] == last_dir[p]) eff_cnt[p] = hold_cnt[p];
      if (eff_cnt[p] >= HOLD_W'(16))     step[p] = YE_W'(4 * STEP);
      else if (eff_cnt[p] >= HOLD_W'(8)) step[p] = YE_W'(2 * STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        hold_cnt[p] <= '0;
        last_dir[p] <= '0;
      end
    end else if (frame_tick) begin
      for (int p = 0; p < 2; p++) begin
        last_dir[p] <= dir[p];
        if (dir[p][0] ^ dir[p][1])
          hold_cnt[p] <= (eff_cnt[p] == HOLD_W'(16)) ? eff_cnt[p] : eff_cnt[p] + HOLD_W'(1);
        else
          hold_cnt[p] <= '0;
      end
    end
  end
`else
  assign step[0] = YE_W'(STEP);
  assign step[1] = YE_W'(STEP);
`endif

  // Saturating move computed one bit wider so the sum cannot wrap.
  function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] y, input logic [1:0] d,
                                            input logic [YE_W-1:0] stp);
    logic [YE_W-1:0] ye;
    logic [YE_W-1:0] sum;
    ye     = YE_W'(y);
    sum    = ye + stp;
    next_y = y;
    if (d == 2'b01)
      next_y = (ye < stp) ? '0 : Y_W'(ye - stp);
    else if (d == 2'b10)
      next_y = (sum > YE_W'(Y_LIM)) ? Y_W'(Y_LIM) : Y_W'(sum);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      paddle1_y <= Y_W'(Y_RST);
      paddle2_y <= Y_W'(Y_RST);
      serve     <= 1'b0;
      db4_q     <= 1'b0;
    end else begin
      db4_q <= btn_db[4];
      serve <= btn_db[4] & ~db4_q;
      if (frame_tick) begin
        paddle1_y <= next_y(paddle1_y, dir[0], step[0]);
        paddle2_y <= next_y(paddle2_y, dir[1], step[1]);
      end
    end
  end

endmodule
